// File: rtl/pkt_hold_buffer.sv
// pkt_hold_buffer
//   Packet and metadata hold buffer for the OpenFlow datapath. Each packet is
//   admitted or dropped as a whole on its first beat. An admitted packet and
//   its tuser are held until the lookup side sends a release. The release
//   either forwards the packet to egress or flushes it from the buffer.
//
// Ports
//   asclk, aresetn        clock, asynchronous active-low reset
//   s_axis_*              ingress AXI-Stream (tready is always 1)
//   rel_valid, rel_drop   in-order release pulse; rel_drop=1 flushes the packet
//   m_axis_*              egress AXI-Stream; tuser is held for the whole packet
//   pkt_buf_drop          one-cycle pulse per packet dropped at ingress
//   rel_overflow          sticky: a release arrived while the credit queue was full
//   pkt_*_cnt             admitted / dropped / forwarded / flushed packet counters
module pkt_hold_buffer #(
  parameter int C_AXIS_DATA_WIDTH     = 64,
  parameter int C_AXIS_TUSER_WIDTH    = 128,
  parameter int C_AXIS_LEN_DATA_WIDTH = 16,
  parameter int BUF_DEPTH_BITS        = 6,
  parameter int META_DEPTH_BITS       = 3,
  parameter int DATA_WIDTH            = 32
) (
  input  logic                            asclk,
  input  logic                            aresetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  input  logic                            rel_valid,
  input  logic                            rel_drop,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic                            pkt_buf_drop,
  output logic                            rel_overflow,
  output logic [DATA_WIDTH-1:0]           pkt_in_cnt,
  output logic [DATA_WIDTH-1:0]           pkt_drop_cnt,
  output logic [DATA_WIDTH-1:0]           pkt_fwd_cnt,
  output logic [DATA_WIDTH-1:0]           pkt_flush_cnt
);

  localparam int BYTES      = C_AXIS_DATA_WIDTH / 8;
  localparam int DEPTH      = 1 << BUF_DEPTH_BITS;
  localparam int META_DEPTH = 1 << META_DEPTH_BITS;
  localparam int PTR_W      = BUF_DEPTH_BITS + 1;
  localparam int MPTR_W     = META_DEPTH_BITS + 1;
  localparam int NEED_W     = C_AXIS_LEN_DATA_WIDTH + 1;
  localparam int CMP_W      = (NEED_W > PTR_W) ? NEED_W : PTR_W;
  localparam int WORD_W     = 1 + BYTES + C_AXIS_DATA_WIDTH;
  localparam int META_W     = C_AXIS_TUSER_WIDTH + PTR_W;

  localparam logic [PTR_W-1:0]      PTR_ONE      = PTR_W'(1);
  localparam logic [PTR_W-1:0]      DEPTH_W      = PTR_W'(DEPTH);
  localparam logic [MPTR_W-1:0]     MPTR_ONE     = MPTR_W'(1);
  localparam logic [MPTR_W-1:0]     META_DEPTH_W = MPTR_W'(META_DEPTH);
  localparam logic [NEED_W-1:0]     NEED_ONE     = NEED_W'(1);
  localparam logic [NEED_W-1:0]     BYTES_N      = NEED_W'(BYTES);
  localparam logic [NEED_W-1:0]     BYTES_M1     = NEED_W'(BYTES - 1);
  localparam logic [DATA_WIDTH-1:0] CNT_ONE      = DATA_WIDTH'(1);

  typedef enum logic [1:0] {IN_IDLE, IN_STORE, IN_DROP} in_state_t;
  typedef enum logic [1:0] {OUT_IDLE, OUT_SEND, OUT_FLUSH} out_state_t;

  // Storage arrays: data words are {tlast, tstrb, tdata}, metadata is
  // {tuser, stored word count}, credits are the release mode bit.
  logic [WORD_W-1:0] data_mem [DEPTH];
  logic [META_W-1:0] meta_mem [META_DEPTH];
  logic              cred_mem [META_DEPTH];

  in_state_t                     in_state_q, in_state_d;
  out_state_t                    out_state_q, out_state_d;
  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]              resv_ptr_q, resv_ptr_d;
  logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]              need_q, need_d;
  logic [PTR_W-1:0]              cnt_q, cnt_d;
  logic [PTR_W-1:0]              remaining_q, remaining_d;
  logic [C_AXIS_TUSER_WIDTH-1:0] pkt_tuser_q, pkt_tuser_d;
  logic [MPTR_W-1:0]             meta_wr_ptr_q, meta_wr_ptr_d;
  logic [MPTR_W-1:0]             meta_rd_ptr_q, meta_rd_ptr_d;
  logic [MPTR_W-1:0]             cred_wr_ptr_q, cred_wr_ptr_d;
  logic [MPTR_W-1:0]             cred_rd_ptr_q, cred_rd_ptr_d;
  logic [C_AXIS_DATA_WIDTH-1:0]  m_tdata_q, m_tdata_d;
  logic [BYTES-1:0]              m_tstrb_q, m_tstrb_d;
  logic [C_AXIS_TUSER_WIDTH-1:0] m_tuser_q, m_tuser_d;
  logic                          m_tvalid_q, m_tvalid_d;
  logic                          m_tlast_q, m_tlast_d;
  logic                          pkt_buf_drop_q, pkt_buf_drop_d;
  logic                          rel_overflow_q, rel_overflow_d;
  logic [DATA_WIDTH-1:0]         in_cnt_q, in_cnt_d;
  logic [DATA_WIDTH-1:0]         drop_cnt_q, drop_cnt_d;
  logic [DATA_WIDTH-1:0]         fwd_cnt_q, fwd_cnt_d;
  logic [DATA_WIDTH-1:0]         flush_cnt_q, flush_cnt_d;

  logic                          data_we;
  logic [BUF_DEPTH_BITS-1:0]     data_waddr;
  logic [WORD_W-1:0]             data_wdata;
  logic                          meta_we;
  logic [META_W-1:0]             meta_wdata;
  logic                          cred_we;

  logic [NEED_W-1:0]             len_ext;
  logic [NEED_W-1:0]             need_div;
  logic [NEED_W-1:0]             need_calc;
  logic [PTR_W-1:0]              free_words;
  logic                          meta_full, meta_empty;
  logic                          cred_full, cred_empty;
  logic                          admit_ok;
  logic [PTR_W-1:0]              cnt_next, wr_next;
  logic [WORD_W-1:0]             rd_word;
  logic [META_W-1:0]             meta_head;
  logic                          cred_head;
  logic                          launch;

  assign s_axis_tready = 1'b1;

  // Admission check: words needed for the advertised length (at least one)
  // against space not yet reserved by earlier packets.
  assign len_ext    = NEED_W'(s_axis_tuser[C_AXIS_LEN_DATA_WIDTH-1:0]);
  assign need_div   = (len_ext + BYTES_M1) / BYTES_N;
  assign need_calc  = (need_div == '0) ? NEED_ONE : need_div;
  assign free_words = DEPTH_W - (resv_ptr_q - rd_ptr_q);
  assign meta_full  = (meta_wr_ptr_q - meta_rd_ptr_q) == META_DEPTH_W;
  assign meta_empty = (meta_wr_ptr_q == meta_rd_ptr_q);
  assign cred_full  = (cred_wr_ptr_q - cred_rd_ptr_q) == META_DEPTH_W;
  assign cred_empty = (cred_wr_ptr_q == cred_rd_ptr_q);
  assign admit_ok   = (CMP_W'(need_calc) <= CMP_W'(free_words)) && !meta_full;

  assign rd_word   = data_mem[rd_ptr_q[BUF_DEPTH_BITS-1:0]];
  assign meta_head = meta_mem[meta_rd_ptr_q[META_DEPTH_BITS-1:0]];
  assign cred_head = cred_mem[cred_rd_ptr_q[META_DEPTH_BITS-1:0]];

  // Ingress: decide admit/drop on the first beat, store up to the reserved
  // word count, then commit metadata on tlast and give back any unused
  // reservation by pulling resv_ptr back to the write pointer.
  always_comb begin
    in_state_d     = in_state_q;
    wr_ptr_d       = wr_ptr_q;
    resv_ptr_d     = resv_ptr_q;
    need_d         = need_q;
    cnt_d          = cnt_q;
    pkt_tuser_d    = pkt_tuser_q;
    meta_wr_ptr_d  = meta_wr_ptr_q;
    pkt_buf_drop_d = 1'b0;
    in_cnt_d       = in_cnt_q;
    drop_cnt_d     = drop_cnt_q;
    data_we        = 1'b0;
    data_waddr     = wr_ptr_q[BUF_DEPTH_BITS-1:0];
    data_wdata     = {s_axis_tlast, s_axis_tstrb, s_axis_tdata};
    meta_we        = 1'b0;
    meta_wdata     = {pkt_tuser_q, cnt_q};
    cnt_next       = cnt_q;
    wr_next        = wr_ptr_q;
    case (in_state_q)
      IN_IDLE: begin
        if (s_axis_tvalid) begin
          if (admit_ok) begin
            data_we    = 1'b1;
            data_wdata = {s_axis_tlast || (need_calc == NEED_ONE), s_axis_tstrb, s_axis_tdata};
            wr_ptr_d   = wr_ptr_q + PTR_ONE;
            need_d     = PTR_W'(need_calc);
            cnt_d      = PTR_ONE;
            if (s_axis_tlast) begin
              meta_we       = 1'b1;
              meta_wdata    = {s_axis_tuser, PTR_ONE};
              meta_wr_ptr_d = meta_wr_ptr_q + MPTR_ONE;
              resv_ptr_d    = wr_ptr_q + PTR_ONE;
              in_cnt_d      = in_cnt_q + CNT_ONE;
            end else begin
              resv_ptr_d  = resv_ptr_q + PTR_W'(need_calc);
              pkt_tuser_d = s_axis_tuser;
              in_state_d  = IN_STORE;
            end
          end else begin
            pkt_buf_drop_d = 1'b1;
            drop_cnt_d     = drop_cnt_q + CNT_ONE;
            if (!s_axis_tlast) in_state_d = IN_DROP;
          end
        end
      end
      IN_STORE: begin
        if (s_axis_tvalid) begin
          // Beats beyond the reservation are discarded; the final reserved
          // word carries tlast so egress still sees a closed packet.
          if (cnt_q < need_q) begin
            data_we    = 1'b1;
            data_wdata = {s_axis_tlast || ((cnt_q + PTR_ONE) == need_q), s_axis_tstrb, s_axis_tdata};
            wr_next    = wr_ptr_q + PTR_ONE;
            cnt_next   = cnt_q + PTR_ONE;
          end
          wr_ptr_d = wr_next;
          cnt_d    = cnt_next;
          if (s_axis_tlast) begin
            meta_we       = 1'b1;
            meta_wdata    = {pkt_tuser_q, cnt_next};
            meta_wr_ptr_d = meta_wr_ptr_q + MPTR_ONE;
            resv_ptr_d    = wr_next;
            in_cnt_d      = in_cnt_q + CNT_ONE;
            in_state_d    = IN_IDLE;
          end
        end
      end
      IN_DROP: begin
        if (s_axis_tvalid && s_axis_tlast) in_state_d = IN_IDLE;
      end
      default: in_state_d = IN_IDLE;
    endcase
  end

  // Release credits: one mode bit per pulse; a pulse into a full queue is
  // lost and latches the overflow flag.
  always_comb begin
    cred_wr_ptr_d  = cred_wr_ptr_q;
    rel_overflow_d = rel_overflow_q;
    cred_we        = 1'b0;
    if (rel_valid) begin
      if (cred_full) begin
        rel_overflow_d = 1'b1;
      end else begin
        cred_we       = 1'b1;
        cred_wr_ptr_d = cred_wr_ptr_q + MPTR_ONE;
      end
    end
  end

  // Egress: pair the oldest credit with the oldest committed packet. A new
  // pair can be popped in the same cycle the previous packet finishes, which
  // keeps back-to-back packets to a single idle cycle.
  always_comb begin
    out_state_d   = out_state_q;
    rd_ptr_d      = rd_ptr_q;
    remaining_d   = remaining_q;
    meta_rd_ptr_d = meta_rd_ptr_q;
    cred_rd_ptr_d = cred_rd_ptr_q;
    m_tdata_d     = m_tdata_q;
    m_tstrb_d     = m_tstrb_q;
    m_tuser_d     = m_tuser_q;
    m_tvalid_d    = m_tvalid_q;
    m_tlast_d     = m_tlast_q;
    fwd_cnt_d     = fwd_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    launch        = 1'b0;
    case (out_state_q)
      OUT_IDLE: begin
        launch = !meta_empty && !cred_empty;
      end
      OUT_SEND: begin
        if (m_tvalid_q && m_axis_tready && (remaining_q == '0)) begin
          m_tvalid_d  = 1'b0;
          m_tlast_d   = 1'b0;
          fwd_cnt_d   = fwd_cnt_q + CNT_ONE;
          out_state_d = OUT_IDLE;
          launch      = !meta_empty && !cred_empty;
        end else if ((!m_tvalid_q || m_axis_tready) && (remaining_q != '0)) begin
          // The word moves into the output register, so its slot is freed now.
          m_tdata_d   = rd_word[C_AXIS_DATA_WIDTH-1:0];
          m_tstrb_d   = rd_word[WORD_W-2 -: BYTES];
          m_tlast_d   = rd_word[WORD_W-1];
          m_tvalid_d  = 1'b1;
          rd_ptr_d    = rd_ptr_q + PTR_ONE;
          remaining_d = remaining_q - PTR_ONE;
        end
      end
      OUT_FLUSH: begin
        rd_ptr_d    = rd_ptr_q + PTR_ONE;
        remaining_d = remaining_q - PTR_ONE;
        if (remaining_q == PTR_ONE) begin
          flush_cnt_d = flush_cnt_q + CNT_ONE;
          out_state_d = OUT_IDLE;
          launch      = !meta_empty && !cred_empty;
        end
      end
      default: out_state_d = OUT_IDLE;
    endcase
    if (launch) begin
      meta_rd_ptr_d = meta_rd_ptr_q + MPTR_ONE;
      cred_rd_ptr_d = cred_rd_ptr_q + MPTR_ONE;
      remaining_d   = meta_head[PTR_W-1:0];
      if (cred_head) begin
        out_state_d = OUT_FLUSH;
      end else begin
        out_state_d = OUT_SEND;
        m_tuser_d   = meta_head[META_W-1 -: C_AXIS_TUSER_WIDTH];
      end
    end
  end

  // Buffer arrays carry no reset; the pointers decide what is valid.
  always_ff @(posedge asclk) begin
    if (data_we) data_mem[data_waddr] <= data_wdata;
    if (meta_we) meta_mem[meta_wr_ptr_q[META_DEPTH_BITS-1:0]] <= meta_wdata;
    if (cred_we) cred_mem[cred_wr_ptr_q[META_DEPTH_BITS-1:0]] <= rel_drop;
  end

  // State, pointers, outputs and counters.
  always_ff @(posedge asclk or negedge aresetn) begin
    if (!aresetn) begin
      in_state_q     <= IN_IDLE;
      out_state_q    <= OUT_IDLE;
      wr_ptr_q       <= '0;
      resv_ptr_q     <= '0;
      rd_ptr_q       <= '0;
      need_q         <= '0;
      cnt_q          <= '0;
      remaining_q    <= '0;
      pkt_tuser_q    <= '0;
      meta_wr_ptr_q  <= '0;
      meta_rd_ptr_q  <= '0;
      cred_wr_ptr_q  <= '0;
      cred_rd_ptr_q  <= '0;
      m_tdata_q      <= '0;
      m_tstrb_q      <= '0;
      m_tuser_q      <= '0;
      m_tvalid_q     <= 1'b0;
      m_tlast_q      <= 1'b0;
      pkt_buf_drop_q <= 1'b0;
      rel_overflow_q <= 1'b0;
      in_cnt_q       <= '0;
      drop_cnt_q     <= '0;
      fwd_cnt_q      <= '0;
      flush_cnt_q    <= '0;
    end else begin
      in_state_q     <= in_state_d;
      out_state_q    <= out_state_d;
      wr_ptr_q       <= wr_ptr_d;
      resv_ptr_q     <= resv_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      need_q         <= need_d;
      cnt_q          <= cnt_d;
      remaining_q    <= remaining_d;
      pkt_tuser_q    <= pkt_tuser_d;
      meta_wr_ptr_q  <= meta_wr_ptr_d;
      meta_rd_ptr_q  <= meta_rd_ptr_d;
      cred_wr_ptr_q  <= cred_wr_ptr_d;
      cred_rd_ptr_q  <= cred_rd_ptr_d;
      m_tdata_q      <= m_tdata_d;
      m_tstrb_q      <= m_tstrb_d;
      m_tuser_q      <= m_tuser_d;
      m_tvalid_q     <= m_tvalid_d;
      m_tlast_q      <= m_tlast_d;
      pkt_buf_drop_q <= pkt_buf_drop_d;
      rel_overflow_q <= rel_overflow_d;
      in_cnt_q       <= in_cnt_d;
      drop_cnt_q     <= drop_cnt_d;
      fwd_cnt_q      <= fwd_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tstrb  = m_tstrb_q;
  assign m_axis_tuser  = m_tuser_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign pkt_buf_drop  = pkt_buf_drop_q;
  assign rel_overflow  = rel_overflow_q;
  assign pkt_in_cnt    = in_cnt_q;
  assign pkt_drop_cnt  = drop_cnt_q;
  assign pkt_fwd_cnt   = fwd_cnt_q;
  assign pkt_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pkt_hold_buffer.sv
// tb_pkt_hold_buffer
//   Directed bench for pkt_hold_buffer with default parameters (64-bit data,
//   64-word buffer, 8-entry metadata/credit queues).
module tb_pkt_hold_buffer;

  logic          asclk = 1'b0;
  logic          aresetn;
  logic [63:0]   s_axis_tdata;
  logic [7:0]    s_axis_tstrb;
  logic [127:0]  s_axis_tuser;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic          rel_valid;
  logic          rel_drop;
  logic [63:0]   m_axis_tdata;
  logic [7:0]    m_axis_tstrb;
  logic [127:0]  m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic          pkt_buf_drop;
  logic          rel_overflow;
  logic [31:0]   pkt_in_cnt;
  logic [31:0]   pkt_drop_cnt;
  logic [31:0]   pkt_fwd_cnt;
  logic [31:0]   pkt_flush_cnt;

  logic          ready_base = 1'b1;
  logic          toggle_en  = 1'b0;
  logic          toggle_ph  = 1'b0;

  int            vectors     = 0;
  int            miscompares = 0;
  int            drop_pulses = 0;
  logic [255:0]  egress_q [$];

  assign m_axis_tready = toggle_en ? toggle_ph : ready_base;

  pkt_hold_buffer dut (
    .asclk         (asclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .rel_valid     (rel_valid),
    .rel_drop      (rel_drop),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .pkt_buf_drop  (pkt_buf_drop),
    .rel_overflow  (rel_overflow),
    .pkt_in_cnt    (pkt_in_cnt),
    .pkt_drop_cnt  (pkt_drop_cnt),
    .pkt_fwd_cnt   (pkt_fwd_cnt),
    .pkt_flush_cnt (pkt_flush_cnt)
  );

  always #5 asclk = ~asclk;

  // Egress ready toggles every cycle when enabled.
  always @(posedge asclk) begin
    #1;
    toggle_ph = ~toggle_ph;
  end

  // Capture each egress handshake and count drop pulses, sampled mid-cycle.
  always @(negedge asclk) begin
    if (aresetn) begin
      if (m_axis_tvalid && m_axis_tready)
        egress_q.push_back({55'b0, m_axis_tuser, m_axis_tstrb, m_axis_tlast, m_axis_tdata});
      if (pkt_buf_drop) drop_pulses++;
    end
  end

  function automatic logic [127:0] mkUser(input int tag, input int lenField);
    logic [127:0] u;
    u        = '0;
    u[23:16] = 8'(tag);
    u[15:0]  = 16'(lenField);
    return u;
  endfunction

  function automatic logic [63:0] mkData(input int tag, input int beat);
    return {32'(tag), 32'(beat)};
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one packet, one beat per cycle; tuser only on the first beat.
  task automatic applyStimulus(input int tag, input int lenField, input int beats, input bit endPkt);
    for (int b = 0; b < beats; b++) begin
      @(posedge asclk); #1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = mkData(tag, b);
      s_axis_tuser  = (b == 0) ? mkUser(tag, lenField) : '0;
      s_axis_tlast  = endPkt && (b == beats - 1);
    end
    @(posedge asclk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic relPulse(input bit drop);
    @(posedge asclk); #1;
    rel_valid = 1'b1;
    rel_drop  = drop;
    @(posedge asclk); #1;
    rel_valid = 1'b0;
    rel_drop  = 1'b0;
  endtask

  task automatic waitFwd(input int target, input int budget);
    int n;
    n = 0;
    while (pkt_fwd_cnt != 32'(target) && n < budget) begin
      @(negedge asclk);
      n++;
    end
    checkOutput($sformatf("fwd_cnt_reach_%0d", target), 256'(pkt_fwd_cnt), 256'(target));
  endtask

  task automatic expectPacket(input int tag, input int nwords, input int lenField);
    logic [255:0] w;
    logic [255:0] e;
    for (int i = 0; i < nwords; i++) begin
      if (egress_q.size() == 0) break;
      w = egress_q.pop_front();
      e = {55'b0, mkUser(tag, lenField), 8'hFF, 1'(i == nwords - 1), mkData(tag, i)};
      checkOutput($sformatf("egress_pkt%0d_w%0d", tag, i), w, e);
    end
  endtask

  initial begin
    aresetn       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tstrb  = 8'hFF;
    s_axis_tuser  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    rel_valid     = 1'b0;
    rel_drop      = 1'b0;

    // Reset state
    repeat (3) @(posedge asclk);
    #1;
    checkOutput("rst_tvalid", 256'(m_axis_tvalid), 256'(0));
    checkOutput("rst_tlast", 256'(m_axis_tlast), 256'(0));
    checkOutput("rst_tdata", 256'(m_axis_tdata), 256'(0));
    checkOutput("rst_tuser", 256'(m_axis_tuser), 256'(0));
    checkOutput("rst_tready", 256'(s_axis_tready), 256'(1));
    checkOutput("rst_counts", 256'({pkt_in_cnt, pkt_drop_cnt, pkt_fwd_cnt, pkt_flush_cnt}), 256'(0));
    checkOutput("rst_flags", 256'({pkt_buf_drop, rel_overflow}), 256'(0));
    aresetn = 1'b1;

    // Three 64-byte packets, then three forwarding releases
    applyStimulus(1, 64, 8, 1'b1);
    applyStimulus(2, 64, 8, 1'b1);
    applyStimulus(3, 64, 8, 1'b1);
    checkOutput("t1_in_cnt", 256'(pkt_in_cnt), 256'(3));
    relPulse(1'b0);
    relPulse(1'b0);
    relPulse(1'b0);
    waitFwd(3, 200);
    checkOutput("t1_words", 256'(egress_q.size()), 256'(24));
    expectPacket(1, 8, 64);
    expectPacket(2, 8, 64);
    expectPacket(3, 8, 64);

    // Fill 56 words, a 9-word packet is dropped, an 8-word packet still fits
    for (int t = 4; t <= 10; t++) applyStimulus(t, 64, 8, 1'b1);
    applyStimulus(11, 72, 9, 1'b1);
    checkOutput("t2_drop_pulses", 256'(drop_pulses), 256'(1));
    checkOutput("t2_drop_cnt", 256'(pkt_drop_cnt), 256'(1));
    applyStimulus(12, 64, 8, 1'b1);
    checkOutput("t2_in_cnt", 256'(pkt_in_cnt), 256'(11));
    for (int r = 0; r < 8; r++) relPulse(1'b0);
    waitFwd(11, 400);
    checkOutput("t2_words", 256'(egress_q.size()), 256'(64));
    for (int t = 4; t <= 10; t++) expectPacket(t, 8, 64);
    expectPacket(12, 8, 64);

    // Flush a 16-byte packet, forward the next one
    applyStimulus(13, 16, 2, 1'b1);
    applyStimulus(14, 64, 8, 1'b1);
    relPulse(1'b1);
    relPulse(1'b0);
    waitFwd(12, 200);
    checkOutput("t3_flush_cnt", 256'(pkt_flush_cnt), 256'(1));
    checkOutput("t3_words", 256'(egress_q.size()), 256'(8));
    expectPacket(14, 8, 64);

    // Early release, 40-byte packet, egress ready toggling
    toggle_en = 1'b1;
    relPulse(1'b0);
    repeat (4) @(posedge asclk);
    applyStimulus(15, 40, 5, 1'b1);
    waitFwd(13, 200);
    checkOutput("t4_words", 256'(egress_q.size()), 256'(5));
    expectPacket(15, 5, 40);
    toggle_en = 1'b0;

    // Length says 16 bytes but four beats arrive: two words kept
    applyStimulus(16, 16, 4, 1'b1);
    relPulse(1'b0);
    waitFwd(14, 200);
    checkOutput("t5_in_cnt", 256'(pkt_in_cnt), 256'(15));
    checkOutput("t5_words", 256'(egress_q.size()), 256'(2));
    expectPacket(16, 2, 16);

    // Nine credits into an eight-entry queue
    for (int r = 0; r < 8; r++) relPulse(1'b0);
    checkOutput("t5_no_overflow", 256'(rel_overflow), 256'(0));
    relPulse(1'b0);
    checkOutput("t5_overflow", 256'(rel_overflow), 256'(1));

    // Reset with egress stalled mid-packet and ingress mid-packet
    ready_base = 1'b0;
    applyStimulus(17, 64, 8, 1'b1);
    applyStimulus(19, 64, 3, 1'b0);
    checkOutput("t6_egress_busy", 256'(m_axis_tvalid), 256'(1));
    @(posedge asclk); #1;
    aresetn = 1'b0;
    #1;
    checkOutput("t6_rst_tvalid", 256'(m_axis_tvalid), 256'(0));
    checkOutput("t6_rst_tdata", 256'(m_axis_tdata), 256'(0));
    checkOutput("t6_rst_tuser", 256'(m_axis_tuser), 256'(0));
    checkOutput("t6_rst_counts", 256'({pkt_in_cnt, pkt_drop_cnt, pkt_fwd_cnt, pkt_flush_cnt}), 256'(0));
    checkOutput("t6_rst_overflow", 256'(rel_overflow), 256'(0));
    repeat (2) @(posedge asclk);
    #1;
    aresetn    = 1'b1;
    ready_base = 1'b1;
    egress_q.delete();
    applyStimulus(18, 64, 8, 1'b1);
    relPulse(1'b0);
    waitFwd(1, 200);
    checkOutput("t6_in_cnt", 256'(pkt_in_cnt), 256'(1));
    checkOutput("t6_words", 256'(egress_q.size()), 256'(8));
    expectPacket(18, 8, 64);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
